// File: rtl/pipeline_skid_register.sv
// Two-entry skid register: one cycle of latency, full throughput.
// in_ready comes straight from a flop, so there is no combinational path from out_ready.
module pipeline_skid_register #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists
          if (out_fire) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_DATA;
          skid_d  = RESET_DATA;
        end
      endcase
    end
  end

  // Handshake outputs are registered copies of the next state's decode.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Bench for pipeline_skid_register: directed scenarios followed by a random run,
// all compared against a queue-based model of the two-entry FIFO.
module tb_pipeline_skid_register;

  localparam int unsigned W     = 16;
  localparam logic [W-1:0] RDAT = 16'hDEAD;

  logic         CLK;
  logic         RESET;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] held;

  pipeline_skid_register #(
    .DATA_W    (W),
    .RESET_DATA(RDAT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".occ"},    64'(occupancy), 64'(mq.size()));
    chk({tag, ".ovld"},   64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".irdy"},   64'(in_ready),  64'(mq.size() < 2));
    chk({tag, ".odat"},   64'(out_data),  64'(held));
  endtask

  // Called at a falling edge; applies inputs, crosses one rising edge, checks at the next falling edge.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input string tag);
    bit ifire, ofire;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    ifire = iv && (mq.size() < 2);
    ofire = ordy && (mq.size() != 0);
    @(posedge CLK);
    if (fl) begin
      mq.delete();
      held = RDAT;
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(d);
      if (mq.size() != 0) held = mq[0];
    end
    @(negedge CLK);
    check_model(tag);
  endtask

  initial begin
    RESET     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    held      = RDAT;
    #2;
    chk("rst.occ",  64'(occupancy), 64'd0);
    chk("rst.ovld", 64'(out_valid), 64'd0);
    chk("rst.irdy", 64'(in_ready),  64'd1);
    chk("rst.odat", 64'(out_data),  64'(RDAT));
    @(negedge CLK);
    RESET = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, "stream");
      chk("stream.dat",  64'(out_data),  64'(i));
      chk("stream.occ",  64'(occupancy), 64'd1);
      chk("stream.irdy", 64'(in_ready),  64'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    chk("drain.ovld", 64'(out_valid), 64'd0);
    chk("drain.hold", 64'(out_data),  64'd4);

    // Backpressure
    cycle(1'b1, 16'h000A, 1'b0, 1'b0, "bp0");
    cycle(1'b1, 16'h000B, 1'b0, 1'b0, "bp1");
    chk("bp.occ2",  64'(occupancy), 64'd2);
    chk("bp.irdy0", 64'(in_ready),  64'd0);
    chk("bp.datA",  64'(out_data),  64'h0A);
    cycle(1'b1, 16'h00FF, 1'b0, 1'b0, "bp_full_hold");
    chk("bp.stillA", 64'(out_data), 64'h0A);
    cycle(1'b0, '0, 1'b1, 1'b0, "bp2");
    chk("bp.datB",  64'(out_data), 64'h0B);
    chk("bp.irdy1", 64'(in_ready), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, "bp3");
    chk("bp.empty", 64'(occupancy), 64'd0);

    // Flush while FULL with a beat offered
    cycle(1'b1, 16'h0011, 1'b0, 1'b0, "fl0");
    cycle(1'b1, 16'h0022, 1'b0, 1'b0, "fl1");
    cycle(1'b1, 16'h000C, 1'b0, 1'b1, "flfull");
    chk("fl.occ",  64'(occupancy), 64'd0);
    chk("fl.ovld", 64'(out_valid), 64'd0);
    chk("fl.irdy", 64'(in_ready),  64'd1);
    chk("fl.odat", 64'(out_data),  64'(RDAT));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, "flpost");
      chk("fl.noC", 64'(out_valid), 64'd0);
    end

    // Flush in HALF while a beat fires in and out: both beats gone
    cycle(1'b1, 16'h0033, 1'b0, 1'b0, "flh0");
    cycle(1'b1, 16'h0044, 1'b1, 1'b1, "flhalf");
    chk("flh.occ", 64'(occupancy), 64'd0);

    // Asynchronous reset while HALF
    cycle(1'b1, 16'h0077, 1'b0, 1'b0, "ar0");
    in_valid = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("ar.ovld", 64'(out_valid), 64'd0);
    chk("ar.occ",  64'(occupancy), 64'd0);
    chk("ar.irdy", 64'(in_ready),  64'd1);
    chk("ar.odat", 64'(out_data),  64'(RDAT));
    mq.delete();
    held = RDAT;
    #1 RESET = 1'b0;
    @(negedge CLK);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0, "ar1");
    chk("ar.dat5", 64'(out_data), 64'h05);
    chk("ar.occ1", 64'(occupancy), 64'd1);

    // Random run
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), W'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
